dram_wr: RTL

Streaming DRAM write engine. It is the write-direction counterpart of the DRAM read path.
- On go, it latches a start address and a word count.
- It accepts that many words from a user-side valid/ready stream and buffers them in an internal FIFO.
- It issues one DRAM write per word to consecutive addresses, honouring dram_ready backpressure, then raises done.

---
 rtl/dram_wr.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dram_wr.sv
`default_nettype none
// ============================================================================
// dram_wr : streaming DRAM write engine, user stream -> FIFO -> DRAM writes
// Rev 1.0
// ============================================================================
module dram_wr #(
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  dram_clk,
  input  logic                  dram_rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  done,
  input  logic                  dram_ready,
  output logic                  dram_wr_en,
  output logic [ADDR_WIDTH-1:0] dram_wr_addr,
  output logic [DATA_WIDTH-1:0] dram_wr_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]        FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]        CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = SIZE_WIDTH'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [SIZE_WIDTH-1:0] size_q, size_d;
  logic [SIZE_WIDTH-1:0] accept_cnt_q, accept_cnt_d;
  logic [SIZE_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  w_push, w_pop, w_full, w_empty;
  logic [SIZE_WIDTH-1:0] w_issue_inc;
  logic [ADDR_WIDTH-1:0] w_issue_off;

  assign w_full  = (count_q == FULL_CNT);
  assign w_empty = (count_q == '0);

  // ready depends only on registered state, never on wr_en
  assign ready   = (state_q == S_XFER) && !w_full && (accept_cnt_q < size_q);
  assign done    = (state_q == S_DONE);
  assign w_push  = wr_en && ready;
  assign w_pop   = dram_wr_en && dram_ready;

  assign dram_wr_en   = !w_empty;
  assign dram_wr_data = w_empty ? '0 : mem_q[rd_ptr_q];
  assign w_issue_inc  = issue_cnt_q + SIZE_ONE;

  // address offset is taken modulo 2^ADDR_WIDTH so the write address wraps
  if (SIZE_WIDTH >= ADDR_WIDTH) begin : g_addr_trunc
    assign w_issue_off = issue_cnt_q[ADDR_WIDTH-1:0];
  end else begin : g_addr_ext
    assign w_issue_off = {{(ADDR_WIDTH-SIZE_WIDTH){1'b0}}, issue_cnt_q};
  end
  assign dram_wr_addr = base_q + w_issue_off;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    size_d       = size_q;
    accept_cnt_d = accept_cnt_q;
    issue_cnt_d  = issue_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          base_d       = start_addr;
          size_d       = size;
          accept_cnt_d = '0;
          issue_cnt_d  = '0;
          state_d      = (size == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (w_push) accept_cnt_d = accept_cnt_q + SIZE_ONE;
        if (w_pop) begin
          issue_cnt_d = w_issue_inc;
          if (w_issue_inc == size_q) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge dram_clk or posedge dram_rst) begin
    if (dram_rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      size_q       <= '0;
      accept_cnt_q <= '0;
      issue_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      size_q       <= size_d;
      accept_cnt_q <= accept_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // storage needs no reset: the flushed count masks stale entries
  always_ff @(posedge dram_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data;
  end

endmodule
`default_nettype wire
